// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame sequencer.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // The sampler's majority vote settles this many edges past mid-bit
  localparam int SAMPLE_DONE_OFS = 2;

  localparam int PRESCALE_8       = 8;
  localparam int PRESCALE_16      = 16;
  localparam int PRESCALE_32      = 32;
  localparam int PRESCALE_DEFAULT = PRESCALE_8;

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter and bit counter.
// The edge counter wraps at 'last_edge'; the bit counter advances on each wrap when bit_en is set.
module uart_rx_edge_bit_cnt #(
  parameter int PRESCALE_WIDTH = 6,
  parameter int BIT_CNT_WIDTH  = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      clear,
  input  logic                      enable,
  input  logic                      bit_en,
  input  logic [PRESCALE_WIDTH-1:0] last_edge,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic [BIT_CNT_WIDTH-1:0]  bit_cnt,
  output logic                      wrap
);

  // Greater-or-equal keeps the counter from running away if last_edge ever shrinks below it
  assign wrap = enable && (edge_cnt >= last_edge);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (clear) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (enable) begin
      if (wrap) begin
        edge_cnt <= '0;
        if (bit_en) begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else begin
        edge_cnt <= edge_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: walks START/DATA/PARITY/STOP, pulses the checker
// and deserializer enables, and reports each frame as valid or dropped.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      PAR_EN,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  input  logic                      STRT_GLITCH,
  input  logic                      PAR_ERR,
  input  logic                      STP_ERR,
  output logic [PRESCALE_WIDTH-1:0] EDGE_CNT,
  output logic                      DAT_SAMP_EN,
  output logic                      STRT_CHK_EN,
  output logic                      DESER_EN,
  output logic                      PAR_CHK_EN,
  output logic                      STP_CHK_EN,
  output logic                      DATA_VALID,
  output logic                      FRM_DROP
);

  localparam int BIT_CNT_WIDTH = $clog2(DATA_WIDTH + 1);

  rx_state_e                 state;
  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic                      par_en_q;
  logic [PRESCALE_WIDTH-1:0] eff_prescale;
  logic [PRESCALE_WIDTH-1:0] last_edge;
  logic [PRESCALE_WIDTH:0]   sample_done;
  logic [BIT_CNT_WIDTH-1:0]  bit_cnt;
  logic                      wrap;
  logic                      start_frame;
  logic                      pre_sample;
  logic                      cnt_en;
  logic                      bit_en;
  logic                      last_bit;

  // Timing is derived from the latched frame config; a zero prescale falls back to 8
  always_comb begin
    eff_prescale = (prescale_q == '0) ? PRESCALE_WIDTH'(PRESCALE_DEFAULT) : prescale_q;
    last_edge    = eff_prescale - 1'b1;
    sample_done  = (PRESCALE_WIDTH+1)'(eff_prescale >> 1) + (PRESCALE_WIDTH+1)'(SAMPLE_DONE_OFS);
    pre_sample   = (({1'b0, EDGE_CNT} + 1'b1) == sample_done) && !wrap;
    cnt_en       = (state != IDLE);
    bit_en       = (state == DATA);
    last_bit     = (bit_cnt == BIT_CNT_WIDTH'(DATA_WIDTH - 1));
    start_frame  = !RX_IN && ((state == IDLE) || ((state == STOP) && wrap));
  end

  uart_rx_edge_bit_cnt #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH),
    .BIT_CNT_WIDTH  (BIT_CNT_WIDTH)
  ) u_cnt (
    .CLK       (CLK),
    .RST       (RST),
    .clear     (start_frame),
    .enable    (cnt_en),
    .bit_en    (bit_en),
    .last_edge (last_edge),
    .edge_cnt  (EDGE_CNT),
    .bit_cnt   (bit_cnt),
    .wrap      (wrap)
  );

  assign DAT_SAMP_EN = (state != IDLE);

  // Enables are set one edge early so the registered pulse lines up with EDGE_CNT == SAMPLE_DONE
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      prescale_q  <= '0;
      par_en_q    <= 1'b0;
      STRT_CHK_EN <= 1'b0;
      DESER_EN    <= 1'b0;
      PAR_CHK_EN  <= 1'b0;
      STP_CHK_EN  <= 1'b0;
      DATA_VALID  <= 1'b0;
      FRM_DROP    <= 1'b0;
    end else begin
      STRT_CHK_EN <= 1'b0;
      DESER_EN    <= 1'b0;
      PAR_CHK_EN  <= 1'b0;
      STP_CHK_EN  <= 1'b0;
      DATA_VALID  <= 1'b0;
      FRM_DROP    <= 1'b0;
      if (start_frame) begin
        prescale_q <= PRESCALE;
        par_en_q   <= PAR_EN;
      end
      case (state)
        IDLE: begin
          if (!RX_IN) state <= START;
        end
        START: begin
          if (pre_sample) STRT_CHK_EN <= 1'b1;
          if (wrap) begin
            if (STRT_GLITCH) begin
              FRM_DROP <= 1'b1;
              state    <= IDLE;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (pre_sample) DESER_EN <= 1'b1;
          if (wrap && last_bit) state <= par_en_q ? PARITY : STOP;
        end
        PARITY: begin
          if (pre_sample) PAR_CHK_EN <= 1'b1;
          if (wrap) begin
            if (PAR_ERR) begin
              FRM_DROP <= 1'b1;
              state    <= IDLE;
            end else begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          if (pre_sample) STP_CHK_EN <= 1'b1;
          if (wrap) begin
            if (STP_ERR) FRM_DROP   <= 1'b1;
            else         DATA_VALID <= 1'b1;
            state <= RX_IN ? IDLE : START;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: expected pulses are queued with their cycle,
// a monitor pops and compares each pulse the DUT emits.
module tb_uart_rx_ctrl;

  localparam int EV_STRT  = 0;
  localparam int EV_DESER = 1;
  localparam int EV_PAR   = 2;
  localparam int EV_STP   = 3;
  localparam int EV_VALID = 4;
  localparam int EV_DROP  = 5;

  typedef struct {
    int kind;
    int cycle;
  } exp_t;

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic [5:0] PRESCALE;
  logic       STRT_GLITCH;
  logic       PAR_ERR;
  logic       STP_ERR;
  logic [5:0] EDGE_CNT;
  logic       DAT_SAMP_EN;
  logic       STRT_CHK_EN;
  logic       DESER_EN;
  logic       PAR_CHK_EN;
  logic       STP_CHK_EN;
  logic       DATA_VALID;
  logic       FRM_DROP;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   last_valid = -100000;
  int   last_drop = -100000;
  exp_t expq[$];

  uart_rx_ctrl #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .PAR_EN      (PAR_EN),
    .PRESCALE    (PRESCALE),
    .STRT_GLITCH (STRT_GLITCH),
    .PAR_ERR     (PAR_ERR),
    .STP_ERR     (STP_ERR),
    .EDGE_CNT    (EDGE_CNT),
    .DAT_SAMP_EN (DAT_SAMP_EN),
    .STRT_CHK_EN (STRT_CHK_EN),
    .DESER_EN    (DESER_EN),
    .PAR_CHK_EN  (PAR_CHK_EN),
    .STP_CHK_EN  (STP_CHK_EN),
    .DATA_VALID  (DATA_VALID),
    .FRM_DROP    (FRM_DROP)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic string kindName(input int k);
    case (k)
      EV_STRT:  return "strt_chk";
      EV_DESER: return "deser";
      EV_PAR:   return "par_chk";
      EV_STP:   return "stp_chk";
      EV_VALID: return "data_valid";
      default:  return "frm_drop";
    endcase
  endfunction

  task automatic push(input int kind, input int cycle);
    exp_t e;
    e.kind  = kind;
    e.cycle = cycle;
    expq.push_back(e);
  endtask

  // outcome: 0 valid, 1 start glitch drop, 2 parity drop, 3 stop drop
  task automatic pushFrame(input int s, input int p, input int pe, input int outcome);
    int sd;
    sd = p / 2 + 2;
    push(EV_STRT, s + sd);
    if (outcome == 1) begin
      push(EV_DROP, s + p);
      return;
    end
    for (int i = 0; i < 8; i++) push(EV_DESER, s + p * (i + 1) + sd);
    if (pe != 0) begin
      push(EV_PAR, s + 9 * p + sd);
      if (outcome == 2) begin
        push(EV_DROP, s + 10 * p);
        return;
      end
    end
    push(EV_STP, s + (9 + pe) * p + sd);
    push((outcome == 3) ? EV_DROP : EV_VALID, s + (10 + pe) * p);
  endtask

  task automatic checkOutput(input int kind);
    exp_t e;
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("[TB] FAIL sb_%s: got pulse at cycle %0d, expected no pulse", kindName(kind), cyc);
    end else begin
      e = expq.pop_front();
      if (e.kind != kind || e.cycle != cyc) begin
        errors++;
        $display("[TB] FAIL sb_%s: got %s at cycle %0d, expected %s at cycle %0d",
                 kindName(kind), kindName(kind), cyc, kindName(e.kind), e.cycle);
      end
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic monitorLoop();
    forever begin
      @(negedge CLK);
      if (STRT_CHK_EN) checkOutput(EV_STRT);
      if (DESER_EN)    checkOutput(EV_DESER);
      if (PAR_CHK_EN)  checkOutput(EV_PAR);
      if (STP_CHK_EN)  checkOutput(EV_STP);
      if (DATA_VALID) begin
        checkOutput(EV_VALID);
        last_valid = cyc;
      end
      if (FRM_DROP) begin
        checkOutput(EV_DROP);
        last_drop = cyc;
      end
    end
  endtask

  task automatic goToCycle(input int c);
    while (cyc < c) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Drives a start bit now; s is the first START cycle
  task automatic applyStimulus(input int p, input bit pe, output int s);
    PRESCALE   = 6'(p);
    PAR_EN     = pe;
    RX_IN      = 1'b0;
    s          = cyc + 1;
    last_valid = -100000;
    last_drop  = -100000;
    goToCycle(s);
    RX_IN = 1'b1;
  endtask

  task automatic checkAllLow(input string tag);
    checkValue({tag, "_edge_cnt"}, int'(EDGE_CNT), 0);
    checkValue({tag, "_samp_en"}, int'(DAT_SAMP_EN), 0);
    checkValue({tag, "_pulses"}, int'({STRT_CHK_EN, DESER_EN, PAR_CHK_EN,
                                       STP_CHK_EN, DATA_VALID, FRM_DROP}), 0);
  endtask

  initial begin
    int s;
    RST         = 1'b0;
    RX_IN       = 1'b1;
    PAR_EN      = 1'b0;
    PRESCALE    = 6'd8;
    STRT_GLITCH = 1'b0;
    PAR_ERR     = 1'b0;
    STP_ERR     = 1'b0;
    fork
      monitorLoop();
    join_none

    goToCycle(3);
    checkAllLow("reset");
    RST = 1'b1;
    goToCycle(cyc + 4);
    checkAllLow("idle");

    // Clean frame, PRESCALE=8 with parity
    applyStimulus(8, 1'b1, s);
    pushFrame(s, 8, 1, 0);
    checkValue("t1_edge_first", int'(EDGE_CNT), 0);
    checkValue("t1_samp_en", int'(DAT_SAMP_EN), 1);
    goToCycle(s + 7);
    checkValue("t1_edge_last", int'(EDGE_CNT), 7);
    goToCycle(s + 8);
    checkValue("t1_edge_wrap", int'(EDGE_CNT), 0);
    goToCycle(s + 90);
    checkValue("t1_valid_cycle", last_valid - s, 88);
    checkValue("t1_back_idle", int'(DAT_SAMP_EN), 0);

    // PRESCALE=16 without parity
    applyStimulus(16, 1'b0, s);
    pushFrame(s, 16, 0, 0);
    goToCycle(s + 162);
    checkValue("t2_valid_cycle", last_valid - s, 160);

    // Start glitch reported after the start check
    applyStimulus(8, 1'b0, s);
    pushFrame(s, 8, 0, 1);
    goToCycle(s + 7);
    STRT_GLITCH = 1'b1;
    goToCycle(s + 8);
    STRT_GLITCH = 1'b0;
    checkValue("t3_drop_now", int'(FRM_DROP), 1);
    checkValue("t3_idle", int'(DAT_SAMP_EN), 0);
    goToCycle(s + 20);
    checkValue("t3_drop_cycle", last_drop - s, 8);

    // Parity error at the parity bit's last edge
    applyStimulus(8, 1'b1, s);
    pushFrame(s, 8, 1, 2);
    goToCycle(s + 79);
    PAR_ERR = 1'b1;
    goToCycle(s + 80);
    PAR_ERR = 1'b0;
    checkValue("t4_idle", int'(DAT_SAMP_EN), 0);
    goToCycle(s + 95);
    checkValue("t4_drop_cycle", last_drop - s, 80);

    // Stop error, PRESCALE=32 without parity
    applyStimulus(32, 1'b0, s);
    pushFrame(s, 32, 0, 3);
    STP_ERR = 1'b1;
    goToCycle(s + 322);
    STP_ERR = 1'b0;
    checkValue("t4b_drop_cycle", last_drop - s, 320);

    // Back-to-back frames: start bit present at the stop bit's last edge
    applyStimulus(8, 1'b1, s);
    pushFrame(s, 8, 1, 0);
    pushFrame(s + 88, 8, 1, 0);
    goToCycle(s + 87);
    RX_IN = 1'b0;
    goToCycle(s + 88);
    RX_IN = 1'b1;
    checkValue("t5_valid1", int'(DATA_VALID), 1);
    checkValue("t5_no_idle", int'(DAT_SAMP_EN), 1);
    checkValue("t5_edge_clear", int'(EDGE_CNT), 0);
    goToCycle(s + 89);
    checkValue("t5_edge_run", int'(EDGE_CNT), 1);
    goToCycle(s + 178);
    checkValue("t5_valid2_cycle", last_valid - s, 176);

    // PRESCALE/PAR_EN changed mid-frame must not affect timing
    applyStimulus(8, 1'b0, s);
    pushFrame(s, 8, 0, 0);
    goToCycle(s + 20);
    PRESCALE = 6'd16;
    PAR_EN   = 1'b1;
    goToCycle(s + 85);
    checkValue("t6_valid_cycle", last_valid - s, 80);

    // Reset in the middle of DATA abandons the frame silently
    applyStimulus(8, 1'b1, s);
    push(EV_STRT, s + 6);
    push(EV_DESER, s + 14);
    push(EV_DESER, s + 22);
    goToCycle(s + 27);
    RST = 1'b0;
    #1;
    checkAllLow("t6_reset");
    goToCycle(cyc + 3);
    RST = 1'b1;
    goToCycle(cyc + 20);
    checkAllLow("t6_after_reset");

    // Recovery frame after reset
    applyStimulus(8, 1'b0, s);
    pushFrame(s, 8, 0, 0);
    goToCycle(s + 100);
    checkValue("t7_valid_cycle", last_valid - s, 80);

    checkValue("sb_drained", expq.size(), 0);
    while (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      $display("[TB] FAIL sb_missing: got nothing, expected %s at cycle %0d", kindName(e.kind), e.cycle);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Frame sequencer for the UART receiver.
- Detects the start bit and counts oversampling edges and bits.
- Issues one-cycle enables to the data sampler, deserializer, start/parity/stop checkers in order, then raises DATA_VALID or drops the frame on error.
- Sits between the RX_IN synchronizer and the checker/deserializer datapath blocks.

Parameters:
DATA_WIDTH, 8, data bits per frame
PRESCALE_WIDTH, 6, width of the oversampling ratio input

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous active-low reset
RX_IN  input  1  serial line, already synchronized to CLK
PAR_EN  input  1  1 = frame carries a parity bit
PRESCALE  input  PRESCALE_WIDTH  oversampling ratio; legal values 8, 16, 32
STRT_GLITCH  input  1  start checker result (registered, valid the cycle after STRT_CHK_EN)
PAR_ERR  input  1  parity checker result (registered, valid the cycle after PAR_CHK_EN)
STP_ERR  input  1  stop checker result (registered, valid the cycle after STP_CHK_EN)
EDGE_CNT  output  PRESCALE_WIDTH  edge index within the current bit, 0..PRESCALE-1
DAT_SAMP_EN  output  1  sampler enable, high in all states except IDLE
STRT_CHK_EN  output  1  one-cycle pulse
DESER_EN  output  1  one-cycle pulse per data bit
PAR_CHK_EN  output  1  one-cycle pulse
STP_CHK_EN  output  1  one-cycle pulse
DATA_VALID  output  1  one-cycle pulse, frame accepted
FRM_DROP  output  1  one-cycle pulse, frame discarded

Behaviour:
- Reset (async, RST=0):
  - State IDLE; EDGE_CNT and bit counter 0.
  - All outputs 0, including the latched PRESCALE/PAR_EN copies.
  - Reset mid-frame abandons the frame with no DATA_VALID or FRM_DROP.
- Timing constants:
  - SAMPLE_DONE = PRESCALE/2 + 2, the edge at which the sampler's majority bit is ready.
  - LAST = PRESCALE - 1.
- Counters:
  - EDGE_CNT increments every cycle outside IDLE and wraps LAST -> 0.
  - The bit counter increments on each wrap in DATA.
  - Both clear on entering START.
- Frame configuration: PRESCALE and PAR_EN are latched on the IDLE->START transition and ignored for the rest of the frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: RX_IN=0 -> START next cycle, with EDGE_CNT=0 in the first START cycle.
  - START:
    - STRT_CHK_EN pulses at EDGE_CNT=SAMPLE_DONE.
    - At EDGE_CNT=LAST: STRT_GLITCH=1 -> IDLE with FRM_DROP pulse; else -> DATA.
  - DATA:
    - DESER_EN pulses at SAMPLE_DONE of each bit.
    - After bit DATA_WIDTH-1 at LAST: -> PARITY if the latched PAR_EN=1, else -> STOP.
  - PARITY:
    - PAR_CHK_EN pulses at SAMPLE_DONE.
    - At LAST: PAR_ERR=1 -> IDLE with FRM_DROP; else -> STOP.
  - STOP:
    - STP_CHK_EN pulses at SAMPLE_DONE.
    - At LAST: STP_ERR=1 gives FRM_DROP; else DATA_VALID.
    - Next state is START if RX_IN=0 at that cycle (back-to-back frame; counters cleared, config re-latched), otherwise IDLE.
- Output timing:
  - DATA_VALID and FRM_DROP are registered and appear the cycle after the deciding LAST edge.
  - They are mutually exclusive.
- Frame length from the first START cycle to DATA_VALID: (2 + DATA_WIDTH + PAR_EN) * PRESCALE cycles.
- Out-of-range PRESCALE gives undefined timing but must not lock the FSM: every state exits within PRESCALE cycles once EDGE_CNT wraps, and PRESCALE=0 is treated as 8.

Decomposition:
- Shared package uart_rx_pkg:
  - state enumeration (IDLE..STOP, binary 3-bit);
  - SAMPLE_DONE offset constant (2);
  - legal prescale constants.
- One natural sub-module: uart_rx_edge_bit_cnt.
  - Contains the EDGE_CNT/bit counter with clear, enable and wrap flag.
  - The FSM stays in uart_rx_ctrl.

Test Plan:
1. PRESCALE=8, PAR_EN=1, clean frame 0xA5 with even parity:
   - STRT_CHK_EN at cycle 6; 8 DESER_EN pulses spaced 8 cycles apart; PAR_CHK_EN and STP_CHK_EN once each.
   - DATA_VALID at cycle 88, FRM_DROP never.
2. PRESCALE=16, PAR_EN=0: frame length 160 cycles; PAR_CHK_EN never asserts; DATA_VALID at cycle 160.
3. STRT_GLITCH=1 forced after STRT_CHK_EN (PRESCALE=8): FRM_DROP at cycle 8, FSM back in IDLE, no DESER_EN.
4. PAR_ERR=1 after PAR_CHK_EN: FRM_DROP one cycle after the parity bit's LAST; no STP_CHK_EN, no DATA_VALID.
5. Two back-to-back frames with RX_IN=0 at the stop LAST edge:
   - DATA_VALID for frame 1, then START entered without an IDLE cycle.
   - Second DATA_VALID exactly 88 cycles later (PRESCALE=8).
6. RST asserted mid-DATA, plus PRESCALE changed mid-frame:
   - Reset drops all outputs to 0 immediately and the FSM returns to IDLE.
   - A PRESCALE change mid-frame does not alter that frame's timing.
